// File: rtl/shared_timer_arbiter.sv
// Round-robin arbiter that shares one down-counting interval timer among
// four requesters. It grants the timer to one owner at a time, counts the
// owner's Tick pulses, and returns a one-cycle Done pulse to that owner.
module shared_timer_arbiter #(
  parameter int unsigned W = 8
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic           Tick,
  input  logic [3:0]     Req,
  input  logic [4*W-1:0] Len,
  output logic [3:0]     Grant,
  output logic           Busy,
  output logic [3:0]     Done,
  output logic [W-1:0]   Count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     owner_q, owner_d;
  logic [1:0]     last_q,  last_d;
  logic [W-1:0]   count_q, count_d;

  logic [1:0]     cand;
  logic [1:0]     winner;
  logic           found;
  logic [W-1:0]   len_win;

  // State register: FSM state, owner, round-robin pointer and count
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= 2'd3;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      count_q <= count_d;
    end
  end

  // Round-robin search starting just after the last owner
  always_comb begin
    cand   = '0;
    winner = '0;
    found  = 1'b0;
    for (int unsigned k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!found && Req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
    len_win = Len[32'(winner)*W +: W];
  end

  // Next-state logic: grant, count, abort and completion
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    count_d = count_q;
    unique case (state_q)
      IDLE: begin
        count_d = '0;
        if (found) begin
          owner_d = winner;
          count_d = len_win;
          state_d = (len_win == '0) ? FIN : RUN;
        end
      end
      RUN: begin
        // Abort wins over a coincident Tick; no Done is produced
        if (!Req[owner_q]) begin
          state_d = IDLE;
          count_d = '0;
          last_d  = owner_q;
        end else if (Tick) begin
          count_d = count_q - W'(1);
          if (count_q == W'(1))
            state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
        count_d = '0;
        last_d  = owner_q;
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  // Moore outputs decoded from the registered state
  always_comb begin
    Grant = '0;
    Done  = '0;
    Busy  = (state_q != IDLE);
    Count = count_q;
    if (state_q != IDLE)
      Grant[owner_q] = 1'b1;
    if (state_q == FIN)
      Done[owner_q] = 1'b1;
  end

endmodule

// File: tb/tb_shared_timer_arbiter.sv
// Directed bench for shared_timer_arbiter: a vector table for the basic
// interval, round-robin and zero-length cases, then hand-written sequences
// for paced ticks, abort, reset mid-interval, fairness and maximum length.
module tb_shared_timer_arbiter;

  localparam int unsigned W = 8;

  logic           Clock;
  logic           Reset;
  logic           Tick;
  logic [3:0]     Req;
  logic [4*W-1:0] Len;
  logic [3:0]     Grant;
  logic           Busy;
  logic [3:0]     Done;
  logic [W-1:0]   Count;

  int total;
  int bad;

  typedef struct {
    logic           rst;
    logic           tick;
    logic [3:0]     req;
    logic [4*W-1:0] len;
    logic [3:0]     g;
    logic           b;
    logic [3:0]     d;
    logic [W-1:0]   c;
  } vec_t;

  vec_t vq[$];

  shared_timer_arbiter #(.W(W)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .Tick  (Tick),
    .Req   (Req),
    .Len   (Len),
    .Grant (Grant),
    .Busy  (Busy),
    .Done  (Done),
    .Count (Count)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [4*W-1:0] lens(input logic [W-1:0] l3, input logic [W-1:0] l2,
                                          input logic [W-1:0] l1, input logic [W-1:0] l0);
    return {l3, l2, l1, l0};
  endfunction

  task automatic step(input logic rst, input logic tick, input logic [3:0] req,
                      input logic [4*W-1:0] len);
    Reset = rst;
    Tick  = tick;
    Req   = req;
    Len   = len;
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [3:0] g, input logic b,
                     input logic [3:0] d, input logic [W-1:0] c);
    total++;
    if (Grant !== g || Busy !== b || Done !== d || Count !== c) begin
      bad++;
      $display("FAIL %s: got grant=%b busy=%b done=%b count=%0d, want grant=%b busy=%b done=%b count=%0d",
               nm, Grant, Busy, Done, Count, g, b, d, c);
    end
  endtask

  task automatic add(input logic rst, input logic tick, input logic [3:0] req,
                     input logic [4*W-1:0] len, input logic [3:0] g, input logic b,
                     input logic [3:0] d, input logic [W-1:0] c);
    vec_t v;
    v.rst = rst; v.tick = tick; v.req = req; v.len = len;
    v.g = g; v.b = b; v.d = d; v.c = c;
    vq.push_back(v);
  endtask

  initial begin
    logic [4*W-1:0] l;
    total = 0;
    bad   = 0;
    Reset = 1'b1;
    Tick  = 1'b0;
    Req   = '0;
    Len   = '0;

    // Single requester, Len0=3, Tick every cycle
    l = lens(0, 0, 0, 3);
    add(1, 0, 4'b0000, l, 4'b0000, 0, 4'b0000, 0);
    add(0, 1, 4'b0001, l, 4'b0001, 1, 4'b0000, 3);
    add(0, 1, 4'b0001, l, 4'b0001, 1, 4'b0000, 2);
    add(0, 1, 4'b0001, l, 4'b0001, 1, 4'b0000, 1);
    add(0, 1, 4'b0001, l, 4'b0001, 1, 4'b0001, 0);
    add(0, 1, 4'b0000, l, 4'b0000, 0, 4'b0000, 0);
    // All four requesting, Len=1 each: order 0,1,2,3,0
    l = lens(1, 1, 1, 1);
    add(1, 0, 4'b1111, l, 4'b0000, 0, 4'b0000, 0);
    for (int unsigned i = 0; i < 5; i++) begin
      add(0, 1, 4'b1111, l, 4'(1 << (i % 4)), 1, 4'b0000, 1);
      add(0, 1, 4'b1111, l, 4'(1 << (i % 4)), 1, 4'(1 << (i % 4)), 0);
      add(0, 1, (i == 4) ? 4'b0000 : 4'b1111, l, 4'b0000, 0, 4'b0000, 0);
    end
    // Zero-length interval for requester 2: grant cycle is already FIN
    l = lens(0, 0, 0, 0);
    add(0, 0, 4'b0100, l, 4'b0100, 1, 4'b0100, 0);
    add(0, 0, 4'b0000, l, 4'b0000, 0, 4'b0000, 0);

    foreach (vq[i]) begin
      step(vq[i].rst, vq[i].tick, vq[i].req, vq[i].len);
      chk($sformatf("vec%0d", i), vq[i].g, vq[i].b, vq[i].d, vq[i].c);
    end

    // Requester 1, Len1=5, Tick every other cycle
    l = lens(0, 0, 5, 0);
    step(0, 0, 4'b0010, l);
    chk("paced_grant", 4'b0010, 1, 4'b0000, 5);
    for (int n = 1; n <= 5; n++) begin
      step(0, 1, 4'b0010, l);
      if (n < 5) chk($sformatf("paced_tick%0d", n), 4'b0010, 1, 4'b0000, W'(5 - n));
      else       chk("paced_done", 4'b0010, 1, 4'b0010, 0);
      if (n < 5) begin
        step(0, 0, 4'b0010, l);
        chk($sformatf("paced_hold%0d", n), 4'b0010, 1, 4'b0000, W'(5 - n));
      end
    end
    step(0, 0, 4'b0000, l);
    chk("paced_idle", 4'b0000, 0, 4'b0000, 0);

    // Abort of requester 1 at Count=2 with coincident Tick; requester 2 pending
    l = lens(0, 3, 4, 0);
    step(1, 0, 4'b0000, l);
    chk("abort_reset", 4'b0000, 0, 4'b0000, 0);
    step(0, 1, 4'b0110, l);
    chk("abort_grant", 4'b0010, 1, 4'b0000, 4);
    step(0, 1, 4'b0110, l);
    chk("abort_c3", 4'b0010, 1, 4'b0000, 3);
    step(0, 1, 4'b0110, l);
    chk("abort_c2", 4'b0010, 1, 4'b0000, 2);
    step(0, 1, 4'b0100, l);
    chk("abort_idle", 4'b0000, 0, 4'b0000, 0);
    step(0, 1, 4'b0100, l);
    chk("abort_next", 4'b0100, 1, 4'b0000, 3);
    step(0, 0, 4'b0000, l);
    chk("abort2_idle", 4'b0000, 0, 4'b0000, 0);

    // Reset mid-RUN restores pointer so requester 0 beats requester 3
    step(0, 0, 4'b0001, lens(0, 0, 0, 4));
    chk("rst_run", 4'b0001, 1, 4'b0000, 4);
    step(1, 1, 4'b0001, lens(0, 0, 0, 4));
    chk("rst_clear", 4'b0000, 0, 4'b0000, 0);
    l = lens(255, 0, 0, 2);
    step(0, 0, 4'b1001, l);
    chk("rst_prio", 4'b0001, 1, 4'b0000, 2);
    step(0, 1, 4'b1001, l);
    chk("rst_c1", 4'b0001, 1, 4'b0000, 1);
    step(0, 1, 4'b1001, l);
    chk("rst_done", 4'b0001, 1, 4'b0001, 0);
    step(0, 0, 4'b1001, l);
    chk("fair_idle", 4'b0000, 0, 4'b0000, 0);

    // Requester 0 still requesting loses to 3; Len3=255 runs to completion
    step(0, 0, 4'b1001, l);
    chk("fair_grant", 4'b1000, 1, 4'b0000, 255);
    for (int n = 1; n <= 255; n++) begin
      step(0, 1, 4'b1001, l);
      if (n < 255) chk($sformatf("max_c%0d", n), 4'b1000, 1, 4'b0000, W'(255 - n));
      else         chk("max_done", 4'b1000, 1, 4'b1000, 0);
    end
    step(0, 0, 4'b0000, l);
    chk("max_idle", 4'b0000, 0, 4'b0000, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
